// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps 00,01,10,11 onto a two-input gate, holds each
// vector HOLD_CYCLES cycles, samples dut_c at the end of the hold window and
// checks it against TRUTH for PASSES sweeps.
// Ports: clk, rst (sync, active high), start, dut_c in; drive_a/drive_b,
// busy, done, pass, err_cnt[7:0], fail_vec[1:0], fail_seen out.
// Optional macro GATE_CHK_FIRST_FAIL_EN enables first-failure capture;
// without it fail_vec/fail_seen are tied low.
module gate_vector_checker #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned PASSES      = 1,
  parameter logic [3:0]  TRUTH       = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_c,
  output logic       drive_a,
  output logic       drive_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [1:0] fail_vec,
  output logic       fail_seen
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [7:0] err_q, err_d;

  logic accept;
  logic sample;
  logic wrap;
  logic last;
  logic mism;

  // start is only honoured outside a run
  assign accept = start && (state_q != S_DRIVE);
  assign sample = (state_q == S_DRIVE) && (hold_q == HOLD_LAST);
  assign wrap   = sample && (vec_q == 2'b11);
  assign last   = wrap && (pcnt_q == PASS_LAST);
  // X/Z on dut_c must register as a mismatch
  assign mism   = sample && (dut_c !== TRUTH[vec_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 2'b00;
      hold_q  <= 8'd0;
      pcnt_q  <= 8'd0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_DRIVE;
      S_DRIVE: if (last) state_d = S_DONE;
      S_DONE:  if (accept) state_d = S_DRIVE;
      default: state_d = S_IDLE;
    endcase
  end

  // Vector wraps back to 00 on the final compare, so the drive pins
  // read 00 in DONE without extra gating.
  always_comb begin
    vec_d  = vec_q;
    hold_d = hold_q;
    pcnt_d = pcnt_q;
    err_d  = err_q;
    if (accept) begin
      vec_d  = 2'b00;
      hold_d = 8'd0;
      pcnt_d = 8'd0;
      err_d  = 8'd0;
    end else if (state_q == S_DRIVE) begin
      hold_d = sample ? 8'd0 : hold_q + 8'd1;
      if (sample) vec_d = vec_q + 2'd1;
      if (wrap) pcnt_d = pcnt_q + 8'd1;
      if (mism && err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  always_comb begin
    busy    = (state_q == S_DRIVE);
    done    = (state_q == S_DONE);
    pass    = done && (err_q == 8'd0);
    drive_a = vec_q[1];
    drive_b = vec_q[0];
    err_cnt = err_q;
  end

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [1:0] fvec_q, fvec_d;
  logic       fseen_q, fseen_d;

  always_comb begin
    fvec_d  = fvec_q;
    fseen_d = fseen_q;
    if (accept) begin
      fvec_d  = 2'b00;
      fseen_d = 1'b0;
    end else if (mism && !fseen_q) begin
      fvec_d  = vec_q;
      fseen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fvec_q  <= 2'b00;
      fseen_q <= 1'b0;
    end else begin
      fvec_q  <= fvec_d;
      fseen_q <= fseen_d;
    end
  end

  assign fail_vec  = fvec_q;
  assign fail_seen = fseen_q;
`else
  assign fail_vec  = 2'b00;
  assign fail_seen = 1'b0;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: scoreboard bench for gate_vector_checker.
// Three instances cover default OR, PASSES=2 and saturation configs.
module tb_gate_vector_checker;

`ifdef GATE_CHK_FIRST_FAIL_EN
  localparam bit FFE = 1'b1;
`else
  localparam bit FFE = 1'b0;
`endif

  typedef struct {
    int inst;
    int cyc;
    int err;
    int pas;
    int fs;
    int fv;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st [3];
  logic       c  [3];
  logic       da [3];
  logic       db [3];
  logic       bz [3];
  logic       dn [3];
  logic       ps [3];
  logic [7:0] ec [3];
  logic [1:0] fv [3];
  logic       fs [3];

  logic dn_prev [3];
  bit   or0 = 1'b1;
  bit   mon1 = 1'b0;
  int   pc = 0;
  int   e0 = 0;
  int   e0_1 = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;

  assign c[0] = or0 ? (da[0] | db[0]) : 1'b0;
  assign c[1] = da[1] & db[1];
  assign c[2] = 1'b1;

  gate_vector_checker u0 (
    .clk(clk), .rst(rst), .start(st[0]), .dut_c(c[0]),
    .drive_a(da[0]), .drive_b(db[0]), .busy(bz[0]), .done(dn[0]),
    .pass(ps[0]), .err_cnt(ec[0]), .fail_vec(fv[0]), .fail_seen(fs[0])
  );

  gate_vector_checker #(.PASSES(2)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .dut_c(c[1]),
    .drive_a(da[1]), .drive_b(db[1]), .busy(bz[1]), .done(dn[1]),
    .pass(ps[1]), .err_cnt(ec[1]), .fail_vec(fv[1]), .fail_seen(fs[1])
  );

  gate_vector_checker #(
    .HOLD_CYCLES(1), .PASSES(100), .TRUTH(4'b0000)
  ) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .dut_c(c[2]),
    .drive_a(da[2]), .drive_b(db[2]), .busy(bz[2]), .done(dn[2]),
    .pass(ps[2]), .err_cnt(ec[2]), .fail_vec(fv[2]), .fail_seen(fs[2])
  );

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Monitor: pop an expectation on each rising done
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (dn[i] && !dn_prev[i]) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: inst %0d at edge %0d", i, pc);
        end else begin
          e = q.pop_front();
          chk("done_inst", i, e.inst);
          chk("done_edge", pc, e.cyc);
          chk("err_cnt", int'(ec[i]), e.err);
          chk("pass", int'(ps[i]), e.pas);
          chk("fail_seen", int'(fs[i]), e.fs);
          chk("fail_vec", int'(fv[i]), e.fv);
          chk("busy_at_done", int'(bz[i]), 0);
          chk("drive_at_done", int'({da[i], db[i]}), 0);
        end
      end
    end
    for (int i = 0; i < 3; i++) dn_prev[i] <= dn[i];
  end

  // u1 drive sequence: 00,01,10,11 twice, four cycles each
  always @(negedge clk) begin
    if (mon1 && bz[1])
      chk("u1_drive", int'({da[1], db[1]}), ((pc - e0_1) / 4) % 4);
  end

  task automatic go(input int i);
    @(negedge clk);
    st[i] = 1'b1;
    e0 = pc + 1;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic upto(input int cy);
    int n = 0;
    while (pc < cy && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: %0d pending, budget %0d", q.size(), budget);
      q.delete();
    end
  endtask

  task automatic chk_zero(input int i, input string nm);
    chk({nm, "_drive"}, int'({da[i], db[i]}), 0);
    chk({nm, "_busy"}, int'(bz[i]), 0);
    chk({nm, "_done"}, int'(dn[i]), 0);
    chk({nm, "_pass"}, int'(ps[i]), 0);
    chk({nm, "_err"}, int'(ec[i]), 0);
    chk({nm, "_fvec"}, int'(fv[i]), 0);
    chk({nm, "_fseen"}, int'(fs[i]), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      dn_prev[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) chk_zero(i, "reset");

    // Correct OR gate, with an ignored start mid-run
    or0 = 1'b1;
    go(0);
    q.push_back('{0, e0 + 16, 0, 1, 0, 0});
    chk("run_busy", int'(bz[0]), 1);
    chk("run_drive", int'({da[0], db[0]}), 0);
    upto(e0 + 4);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    drain(40);

    // Stuck-at-0 against OR, started from DONE
    or0 = 1'b0;
    go(0);
    q.push_back('{0, e0 + 16, 3, 0, int'(FFE), FFE ? 1 : 0});
    upto(e0 + 8);
    chk("err_after_first", int'(ec[0]), 1);
    chk("fseen_after_first", int'(fs[0]), int'(FFE));
    drain(40);

    // Restart from DONE clears the previous result
    or0 = 1'b1;
    go(0);
    chk("restart_err", int'(ec[0]), 0);
    chk("restart_done", int'(dn[0]), 0);
    chk("restart_fseen", int'(fs[0]), 0);
    q.push_back('{0, e0 + 16, 0, 1, 0, 0});
    drain(40);

    // Reset at cycle 6 of a run
    or0 = 1'b0;
    go(0);
    upto(e0 + 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero(0, "midrst");
    repeat (20) @(negedge clk);
    chk("midrst_idle_done", int'(dn[0]), 0);
    or0 = 1'b1;
    go(0);
    q.push_back('{0, e0 + 16, 0, 1, 0, 0});
    drain(40);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1;
    st[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    st[0] = 1'b0;
    chk("rst_wins_busy", int'(bz[0]), 0);
    chk("rst_wins_done", int'(dn[0]), 0);

    // AND gate against OR table, two sweeps
    go(1);
    e0_1 = e0;
    mon1 = 1'b1;
    q.push_back('{1, e0 + 32, 4, 0, int'(FFE), FFE ? 1 : 0});
    drain(60);
    mon1 = 1'b0;

    // Stuck-at-1 vs all-zero table: 400 mismatches saturate
    go(2);
    q.push_back('{2, e0 + 400, 255, 0, int'(FFE), 0});
    drain(500);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
